i2c_txn_ctrl: RTL and testbench
===============================

# i2c_txn_ctrl

Transaction controller sitting directly upstream of the I2C master bit engine (the start/write/read/stop state machine). Turns a single register-access request (device address, register address, write data or read) into the ordered command sequence the bit engine executes. Checks the slave ACK after every written byte, retries NACKed transactions, and returns read data or an error to the requester.

## Interface
Parameters:
- MAX_RETRIES, 3, extra attempts after a NACK. Total attempts = 1 + MAX_RETRIES. Range 0..7.

Ports:
- clk  in  1  system clock, same domain as the bit engine.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request strobe.
- req_ready  out  1  controller idle; request accepted when req_valid && req_ready.
- req_rnw  in  1  1 = register read, 0 = register write.
- req_dev_addr  in  7  7-bit slave address.
- req_reg_addr  in  8  register address.
- req_wdata  in  8  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse; transaction finished.
- rsp_rdata  out  8  read data; valid with rsp_valid for a successful read, 0 otherwise.
- rsp_error  out  1  valid with rsp_valid; 1 = all attempts NACKed.
- cmd_valid  out  1  command to bit engine is valid.
- cmd_ready  in  1  bit engine accepts command.
- cmd_op  out  2  00 START, 01 WRITE, 10 READ, 11 STOP.
- cmd_wdata  out  8  byte for WRITE, 0 otherwise.
- cmd_done  in  1  one-cycle pulse; accepted command complete.
- cmd_ack_rx  in  1  with cmd_done after WRITE: 1 = slave ACKed.
- cmd_rdata  in  8  with cmd_done after READ: received byte. The bit engine always NACKs the single read byte.

## Operation
- Request fields are captured into internal registers on acceptance. Inputs are don't-care afterwards.
- Write sequence: START, WRITE {dev,0}, WRITE reg, WRITE wdata, STOP, RESP.
- Read sequence: START, WRITE {dev,0}, WRITE reg, START (repeated), WRITE {dev,1}, READ, STOP, RESP.
- States: IDLE, START, DEV_W, REG, DATA, RSTART, DEV_R, READ, STOP, RESP.
- Each command state has two phases:
  - ISSUE: cmd_valid held high with cmd_op and cmd_wdata stable until cmd_ready.
  - WAIT: cmd_valid low until cmd_done.
- The state advances only on cmd_done. cmd_done while cmd_valid is high is ignored.
- NACK (cmd_done && !cmd_ack_rx) after any WRITE jumps to STOP.
  - After that STOP completes: if attempts used < 1 + MAX_RETRIES, increment the attempt counter and go to START (full sequence replayed).
  - Otherwise go to RESP with the error flag set.
- READ captures cmd_rdata on cmd_done.
- RESP lasts one cycle: rsp_valid = 1 with rsp_error and rsp_rdata, then IDLE. The attempt counter and error flag clear on entry to IDLE.
- A successful write reports rsp_rdata = 0 and rsp_error = 0.
- reset mid-transaction: all outputs return to reset values immediately and state goes to IDLE. No STOP is issued; the bit engine shares the reset.

## Timing
- Reset values:
  - req_ready = 1
  - cmd_valid = 0, cmd_op = 00, cmd_wdata = 0
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0
- All outputs are registered.
- req_ready drops the cycle after acceptance and is high only in IDLE.
- cmd_valid (START) rises the cycle after request acceptance.
- After cmd_done, the next command's cmd_valid rises the following cycle.
- cmd_valid falls the cycle after the cmd_valid && cmd_ready handshake.
- rsp_valid rises the cycle after the final STOP's cmd_done and lasts exactly one cycle.
- req_ready rises the cycle after rsp_valid, so a back-to-back request is accepted no earlier than 2 cycles after the final STOP's cmd_done.
- Minimum latency, request accept to rsp_valid, with a zero-delay bit engine (cmd_ready tied 1, cmd_done one cycle after acceptance):
  - write: 5 commands × 2 cycles + 1 = 11 cycles.
  - read: 7 × 2 + 1 = 15 cycles.
- MAX_RETRIES = 0: the first NACK produces the error response after its STOP.

## Test plan
- Write dev 0x50, reg 0x10, data 0xA5, all ACK -> commands START, WRITE 0xA0, WRITE 0x10, WRITE 0xA5, STOP in order; rsp_valid one cycle, rsp_error = 0, rsp_rdata = 0x00.
- Read dev 0x50, reg 0x22, bit engine returns 0x3C -> START, WRITE 0xA0, WRITE 0x22, START, WRITE 0xA1, READ, STOP; rsp_rdata = 0x3C, rsp_error = 0.
- Device-address NACK on every attempt, MAX_RETRIES = 3 -> exactly 4 START/WRITE 0xA0/STOP triplets, then rsp_error = 1; req_ready high the following cycle.
- NACK on the first attempt's data byte, ACK on the second -> one STOP after the NACK, one full replay, rsp_error = 0.
- cmd_ready held low 5 cycles -> cmd_valid, cmd_op and cmd_wdata stable throughout; a spurious cmd_done while cmd_valid is high is ignored.
- reset asserted while waiting in REG -> next sample shows all reset values and req_ready = 1; after release, a new write completes normally.

Source files
------------

// File: rtl/i2c_txn_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_txn_ctrl
//
// Purpose:
//   Register-access transaction controller that sits in front of the I2C
//   master bit engine. A single request (device address, register address,
//   write data or read) is turned into the ordered START / WRITE / READ /
//   STOP command stream the bit engine executes. Every written byte has its
//   slave ACK checked; a NACK aborts the attempt with a STOP and the whole
//   sequence is replayed up to MAX_RETRIES more times before an error
//   response is returned.
//
// Parameters:
//   MAX_RETRIES    extra attempts after a NACK (0..7), total = 1 + MAX_RETRIES
//
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   req_*          request channel (valid/ready), fields captured on accept
//   rsp_*          one-cycle response pulse with read data and error flag
//   cmd_valid/op/wdata, cmd_ready   command channel to the bit engine
//   cmd_done/ack_rx/rdata           completion report from the bit engine
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module i2c_txn_ctrl #(
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_op,
  output logic [7:0] cmd_wdata,
  input  logic       cmd_done,
  input  logic       cmd_ack_rx,
  input  logic [7:0] cmd_rdata
);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_DEV_W,
    S_REG,
    S_DATA,
    S_RSTART,
    S_DEV_R,
    S_READ,
    S_STOP,
    S_RESP
  } state_e;

  // Every command state is split into an ISSUE phase (cmd_valid high until
  // the bit engine takes it) and a WAIT phase (cmd_valid low until done).
  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_e;

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  logic       rnw_q, rnw_d;
  logic [6:0] dev_addr_q, dev_addr_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic [2:0] attempt_q, attempt_d;
  logic       nack_q, nack_d;

  logic       req_ready_q, req_ready_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [1:0] cmd_op_q, cmd_op_d;
  logic [7:0] cmd_wdata_q, cmd_wdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_error_q, rsp_error_d;

  logic       launch;
  logic [9:0] cmd_word;
  logic       is_write_state;

  // Opcode and byte for the command a given state issues. Non-WRITE
  // commands always carry a zero byte.
  function automatic logic [9:0] cmd_for(input state_e     s,
                                         input logic [6:0] dev,
                                         input logic [7:0] ra,
                                         input logic [7:0] wd);
    logic [9:0] w;
    w = {OP_START, 8'h00};
    case (s)
      S_START, S_RSTART: w = {OP_START, 8'h00};
      S_DEV_W:           w = {OP_WRITE, dev, 1'b0};
      S_REG:             w = {OP_WRITE, ra};
      S_DATA:            w = {OP_WRITE, wd};
      S_DEV_R:           w = {OP_WRITE, dev, 1'b1};
      S_READ:            w = {OP_READ, 8'h00};
      S_STOP:            w = {OP_STOP, 8'h00};
      default:           w = {OP_START, 8'h00};
    endcase
    return w;
  endfunction

  // Next-state and next-output computation. Outputs are computed for the
  // state being entered so that the registered versions line up with it:
  // a new command's cmd_valid appears the cycle after the previous done.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    rnw_d       = rnw_q;
    dev_addr_d  = dev_addr_q;
    reg_addr_d  = reg_addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    attempt_d   = attempt_q;
    nack_d      = nack_q;
    req_ready_d = req_ready_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_wdata_d = cmd_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    launch      = 1'b0;
    cmd_word    = '0;

    is_write_state = (state_q == S_DEV_W) || (state_q == S_REG) ||
                     (state_q == S_DATA)  || (state_q == S_DEV_R);

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          rnw_d       = req_rnw;
          dev_addr_d  = req_dev_addr;
          reg_addr_d  = req_reg_addr;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          state_d     = S_START;
          launch      = 1'b1;
        end
      end

      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rsp_rdata_d = 8'h00;
        rsp_error_d = 1'b0;
        attempt_d   = '0;
        nack_d      = 1'b0;
      end

      default: begin
        if (phase_q == PH_ISSUE) begin
          // cmd_done seen here belongs to nothing we issued and is ignored.
          if (cmd_ready) begin
            cmd_valid_d = 1'b0;
            phase_d     = PH_WAIT;
          end
        end else if (cmd_done) begin
          if (is_write_state && !cmd_ack_rx) begin
            nack_d = 1'b1;
          end
          case (state_q)
            S_START:  state_d = S_DEV_W;
            S_DEV_W:  state_d = cmd_ack_rx ? S_REG : S_STOP;
            S_REG: begin
              if (!cmd_ack_rx) begin
                state_d = S_STOP;
              end else if (rnw_q) begin
                state_d = S_RSTART;
              end else begin
                state_d = S_DATA;
              end
            end
            S_DATA:   state_d = S_STOP;
            S_RSTART: state_d = S_DEV_R;
            S_DEV_R:  state_d = cmd_ack_rx ? S_READ : S_STOP;
            S_READ: begin
              rdata_d = cmd_rdata;
              state_d = S_STOP;
            end
            S_STOP: begin
              // A STOP that closes a NACKed attempt either replays the whole
              // sequence or, once the attempts are used up, reports failure.
              if (nack_q) begin
                if (attempt_q < 3'(MAX_RETRIES)) begin
                  attempt_d = attempt_q + 3'd1;
                  nack_d    = 1'b0;
                  state_d   = S_START;
                end else begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_error_d = 1'b1;
                  rsp_rdata_d = 8'h00;
                end
              end else begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_error_d = 1'b0;
                rsp_rdata_d = rnw_q ? rdata_q : 8'h00;
              end
            end
            default:  state_d = S_IDLE;
          endcase
          launch = (state_d != S_RESP) && (state_d != S_IDLE);
        end
      end
    endcase

    if (launch) begin
      cmd_word    = cmd_for(state_d, dev_addr_d, reg_addr_d, wdata_d);
      cmd_valid_d = 1'b1;
      phase_d     = PH_ISSUE;
      cmd_op_d    = cmd_word[9:8];
      cmd_wdata_d = cmd_word[7:0];
    end
  end

  // State and output registers; reset abandons any transaction in flight
  // without a STOP since the bit engine is reset alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_ISSUE;
      rnw_q       <= 1'b0;
      dev_addr_q  <= '0;
      reg_addr_q  <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      attempt_q   <= '0;
      nack_q      <= 1'b0;
      req_ready_q <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_START;
      cmd_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      rnw_q       <= rnw_d;
      dev_addr_q  <= dev_addr_d;
      reg_addr_q  <= reg_addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      attempt_q   <= attempt_d;
      nack_q      <= nack_d;
      req_ready_q <= req_ready_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_wdata_q <= cmd_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready = req_ready_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_wdata = cmd_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_i2c_txn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2c_txn_ctrl
//
// Drives register-access requests into i2c_txn_ctrl while a behavioural bit
// engine answers the command channel with programmable ready/done delays,
// per-attempt NACK injection and read bytes. Every command the controller
// issues is logged and compared with the sequence expected from the
// transaction rules.
// ---------------------------------------------------------------------------
module tb_i2c_txn_ctrl;

  localparam int MAX_RETRIES = 3;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_rnw;
  logic [6:0] req_dev_addr;
  logic [7:0] req_reg_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_wdata;
  logic       cmd_done;
  logic       cmd_ack_rx;
  logic [7:0] cmd_rdata;

  int tot = 0;
  int bad = 0;

  // Bit engine configuration and bookkeeping.
  int         ready_delay = 0;
  int         done_delay  = 0;
  bit         spurious_en = 0;
  logic [7:0] rd_byte     = 8'h00;
  int         nack_at[8];
  int         eng_attempt = 0;
  int         wr_idx      = 0;
  int         ready_cnt   = 0;
  int         done_cnt    = 0;
  bit         busy        = 0;
  bit         seen        = 0;
  logic [9:0] held        = '0;
  logic       pend_ack    = 1'b1;
  logic [7:0] pend_rdata  = 8'h00;

  logic [9:0] cmd_log[$];
  logic [9:0] exp_log[$];
  logic       exp_err;
  logic [7:0] exp_rd;

  // Results of the last drive_txn call.
  int         lat;
  logic       got_err;
  logic [7:0] got_rd;
  logic       rdy_acc;
  logic       v_after;
  logic       r_after;
  logic       tmo;

  i2c_txn_ctrl #(.MAX_RETRIES(MAX_RETRIES)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rnw      (req_rnw),
    .req_dev_addr (req_dev_addr),
    .req_reg_addr (req_reg_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_wdata    (cmd_wdata),
    .cmd_done     (cmd_done),
    .cmd_ack_rx   (cmd_ack_rx),
    .cmd_rdata    (cmd_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural bit engine, acting on falling edges so the controller sees
  // stable inputs at the rising edge. It logs each accepted command, checks
  // that a stalled command stays put, and can fire a stray cmd_done while a
  // command is still waiting for ready.
  initial begin
    cmd_ready  = 1'b0;
    cmd_done   = 1'b0;
    cmd_ack_rx = 1'b0;
    cmd_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      cmd_done   = 1'b0;
      cmd_ack_rx = 1'b0;
      cmd_rdata  = 8'h00;
      if (reset) begin
        busy      = 0;
        seen      = 0;
        cmd_ready = 1'b0;
      end else if (busy) begin
        cmd_ready = 1'b0;
        if (done_cnt == 0) begin
          cmd_done   = 1'b1;
          cmd_ack_rx = pend_ack;
          cmd_rdata  = pend_rdata;
          busy       = 0;
        end else begin
          done_cnt--;
        end
      end else if (cmd_valid) begin
        if (!seen) begin
          held = {cmd_op, cmd_wdata};
          seen = 1;
        end else begin
          tot++;
          if ({cmd_op, cmd_wdata} !== held) begin
            bad++;
            $display("[TB] FAIL cmd_stable: got %h expected %h", {cmd_op, cmd_wdata}, held);
          end
        end
        if (ready_cnt > 0) begin
          cmd_ready = 1'b0;
          ready_cnt--;
          if (spurious_en && ready_cnt == 2) begin
            cmd_done   = 1'b1;
            cmd_ack_rx = 1'b0;
            cmd_rdata  = 8'hFF;
          end
        end else begin
          cmd_ready = 1'b1;
          cmd_log.push_back({cmd_op, cmd_wdata});
          busy       = 1;
          seen       = 0;
          done_cnt   = done_delay;
          ready_cnt  = ready_delay;
          pend_ack   = 1'b1;
          pend_rdata = 8'h00;
          if (cmd_op == 2'b01) begin
            pend_ack = (eng_attempt < 8) ? (nack_at[eng_attempt] != wr_idx) : 1'b1;
            wr_idx++;
          end else if (cmd_op == 2'b10) begin
            pend_rdata = rd_byte;
          end else if (cmd_op == 2'b11) begin
            eng_attempt++;
            wr_idx = 0;
          end
        end
      end else begin
        cmd_ready = 1'b0;
      end
    end
  end

  // Reference model: the command list and response a request must produce,
  // built attempt by attempt from the current NACK plan. Write positions
  // within an attempt are numbered 0 (device), 1 (register), 2 (data or
  // device-read).
  task automatic build_expected(input logic rnw, input logic [6:0] dev,
                                input logic [7:0] ra, input logic [7:0] wd,
                                input logic [7:0] rdb);
    bit done;
    exp_log.delete();
    done    = 0;
    exp_err = 1'b1;
    exp_rd  = 8'h00;
    for (int a = 0; a <= MAX_RETRIES && !done; a++) begin
      exp_log.push_back({2'b00, 8'h00});
      exp_log.push_back({2'b01, dev, 1'b0});
      if (nack_at[a] == 0) begin exp_log.push_back({2'b11, 8'h00}); continue; end
      exp_log.push_back({2'b01, ra});
      if (nack_at[a] == 1) begin exp_log.push_back({2'b11, 8'h00}); continue; end
      if (rnw) begin
        exp_log.push_back({2'b00, 8'h00});
        exp_log.push_back({2'b01, dev, 1'b1});
        if (nack_at[a] == 2) begin exp_log.push_back({2'b11, 8'h00}); continue; end
        exp_log.push_back({2'b10, 8'h00});
        exp_rd = rdb;
      end else begin
        exp_log.push_back({2'b01, wd});
        if (nack_at[a] == 2) begin exp_log.push_back({2'b11, 8'h00}); continue; end
      end
      exp_log.push_back({2'b11, 8'h00});
      exp_err = 1'b0;
      done    = 1;
    end
  endtask

  // Issues one request and waits (bounded) for its response. Request fields
  // are scrambled right after acceptance since the controller must have
  // captured them.
  task automatic drive_txn(input logic rnw, input logic [6:0] dev,
                           input logic [7:0] ra, input logic [7:0] wd);
    int n;
    cmd_log.delete();
    eng_attempt = 0;
    wr_idx      = 0;
    ready_cnt   = ready_delay;
    lat = 0; got_err = 1'b0; got_rd = 8'h00; v_after = 1'b0; r_after = 1'b0; tmo = 1'b0;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    req_rnw      = rnw;
    req_dev_addr = dev;
    req_reg_addr = ra;
    req_wdata    = wd;
    req_valid    = 1'b1;
    @(negedge clk);
    req_valid    = 1'b0;
    req_rnw      = $urandom_range(0, 1);
    req_dev_addr = 7'($urandom);
    req_reg_addr = 8'($urandom);
    req_wdata    = 8'($urandom);
    rdy_acc      = req_ready;
    n = 1;
    while (!rsp_valid && n < 4000) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      tmo = 1'b1;
    end else begin
      lat     = n;
      got_err = rsp_error;
      got_rd  = rsp_rdata;
      @(negedge clk);
      v_after = rsp_valid;
      r_after = req_ready;
    end
  endtask

  task automatic clear_nacks();
    for (int i = 0; i < 8; i++) nack_at[i] = 7;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_rnw = 1'b0; req_dev_addr = '0; req_reg_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    tot += 7;
    if (req_ready !== 1'b1)    begin bad++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    if (cmd_valid !== 1'b0)    begin bad++; $display("[TB] FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
    if (cmd_op !== 2'b00)      begin bad++; $display("[TB] FAIL reset_cmd_op: got %b expected 00", cmd_op); end
    if (cmd_wdata !== 8'h00)   begin bad++; $display("[TB] FAIL reset_cmd_wdata: got %h expected 00", cmd_wdata); end
    if (rsp_valid !== 1'b0)    begin bad++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    if (rsp_rdata !== 8'h00)   begin bad++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 00", rsp_rdata); end
    if (rsp_error !== 1'b0)    begin bad++; $display("[TB] FAIL reset_rsp_error: got %b expected 0", rsp_error); end
    reset = 1'b0;
  endtask

  task automatic test_write();
    clear_nacks();
    ready_delay = 0; done_delay = 0; spurious_en = 0;
    drive_txn(1'b0, 7'h50, 8'h10, 8'hA5);
    exp_log.delete();
    exp_log.push_back(10'h000); exp_log.push_back(10'h1A0); exp_log.push_back(10'h110);
    exp_log.push_back(10'h1A5); exp_log.push_back(10'h300);
    tot += 7;
    if (tmo !== 1'b0)            begin bad++; $display("[TB] FAIL write_timeout: got %b expected 0", tmo); end
    if (cmd_log.size() != 5)     begin bad++; $display("[TB] FAIL write_len: got %0d expected 5", cmd_log.size()); end
    if (lat != 11)               begin bad++; $display("[TB] FAIL write_latency: got %0d expected 11", lat); end
    if (rdy_acc !== 1'b0)        begin bad++; $display("[TB] FAIL write_ready_drop: got %b expected 0", rdy_acc); end
    if (got_err !== 1'b0 || got_rd !== 8'h00)
      begin bad++; $display("[TB] FAIL write_rsp: got err=%b rd=%h expected err=0 rd=00", got_err, got_rd); end
    if (v_after !== 1'b0)        begin bad++; $display("[TB] FAIL write_rsp_pulse: got %b expected 0", v_after); end
    if (r_after !== 1'b1)        begin bad++; $display("[TB] FAIL write_ready_back: got %b expected 1", r_after); end
    for (int i = 0; i < exp_log.size() && i < cmd_log.size(); i++) begin
      tot++;
      if (cmd_log[i] !== exp_log[i]) begin bad++; $display("[TB] FAIL write_cmd[%0d]: got %h expected %h", i, cmd_log[i], exp_log[i]); end
    end
  endtask

  task automatic test_read();
    clear_nacks();
    ready_delay = 0; done_delay = 0; spurious_en = 0; rd_byte = 8'h3C;
    drive_txn(1'b1, 7'h50, 8'h22, 8'h77);
    exp_log.delete();
    exp_log.push_back(10'h000); exp_log.push_back(10'h1A0); exp_log.push_back(10'h122);
    exp_log.push_back(10'h000); exp_log.push_back(10'h1A1); exp_log.push_back(10'h200);
    exp_log.push_back(10'h300);
    tot += 4;
    if (tmo !== 1'b0)            begin bad++; $display("[TB] FAIL read_timeout: got %b expected 0", tmo); end
    if (cmd_log.size() != 7)     begin bad++; $display("[TB] FAIL read_len: got %0d expected 7", cmd_log.size()); end
    if (lat != 15)               begin bad++; $display("[TB] FAIL read_latency: got %0d expected 15", lat); end
    if (got_err !== 1'b0 || got_rd !== 8'h3C)
      begin bad++; $display("[TB] FAIL read_rsp: got err=%b rd=%h expected err=0 rd=3c", got_err, got_rd); end
    for (int i = 0; i < exp_log.size() && i < cmd_log.size(); i++) begin
      tot++;
      if (cmd_log[i] !== exp_log[i]) begin bad++; $display("[TB] FAIL read_cmd[%0d]: got %h expected %h", i, cmd_log[i], exp_log[i]); end
    end
  endtask

  task automatic test_dev_nack();
    clear_nacks();
    for (int i = 0; i < 8; i++) nack_at[i] = 0;
    ready_delay = 0; done_delay = 1; spurious_en = 0;
    drive_txn(1'b0, 7'h50, 8'h10, 8'hA5);
    exp_log.delete();
    for (int a = 0; a < 4; a++) begin
      exp_log.push_back(10'h000); exp_log.push_back(10'h1A0); exp_log.push_back(10'h300);
    end
    tot += 4;
    if (tmo !== 1'b0)            begin bad++; $display("[TB] FAIL devnack_timeout: got %b expected 0", tmo); end
    if (cmd_log.size() != 12)    begin bad++; $display("[TB] FAIL devnack_len: got %0d expected 12", cmd_log.size()); end
    if (got_err !== 1'b1 || got_rd !== 8'h00)
      begin bad++; $display("[TB] FAIL devnack_rsp: got err=%b rd=%h expected err=1 rd=00", got_err, got_rd); end
    if (r_after !== 1'b1)        begin bad++; $display("[TB] FAIL devnack_ready_back: got %b expected 1", r_after); end
    for (int i = 0; i < exp_log.size() && i < cmd_log.size(); i++) begin
      tot++;
      if (cmd_log[i] !== exp_log[i]) begin bad++; $display("[TB] FAIL devnack_cmd[%0d]: got %h expected %h", i, cmd_log[i], exp_log[i]); end
    end
  endtask

  task automatic test_data_nack_retry();
    clear_nacks();
    nack_at[0] = 2;
    ready_delay = 1; done_delay = 0; spurious_en = 0;
    drive_txn(1'b0, 7'h50, 8'h10, 8'hA5);
    exp_log.delete();
    for (int a = 0; a < 2; a++) begin
      exp_log.push_back(10'h000); exp_log.push_back(10'h1A0); exp_log.push_back(10'h110);
      exp_log.push_back(10'h1A5); exp_log.push_back(10'h300);
    end
    tot += 3;
    if (tmo !== 1'b0)            begin bad++; $display("[TB] FAIL retry_timeout: got %b expected 0", tmo); end
    if (cmd_log.size() != 10)    begin bad++; $display("[TB] FAIL retry_len: got %0d expected 10", cmd_log.size()); end
    if (got_err !== 1'b0 || got_rd !== 8'h00)
      begin bad++; $display("[TB] FAIL retry_rsp: got err=%b rd=%h expected err=0 rd=00", got_err, got_rd); end
    for (int i = 0; i < exp_log.size() && i < cmd_log.size(); i++) begin
      tot++;
      if (cmd_log[i] !== exp_log[i]) begin bad++; $display("[TB] FAIL retry_cmd[%0d]: got %h expected %h", i, cmd_log[i], exp_log[i]); end
    end
  endtask

  // Commands stall five cycles on ready with a stray cmd_done in the middle;
  // the engine process checks the command stays stable while stalled.
  task automatic test_stall();
    clear_nacks();
    ready_delay = 5; done_delay = 2; spurious_en = 1; rd_byte = 8'h96;
    drive_txn(1'b1, 7'h2B, 8'h5E, 8'h00);
    build_expected(1'b1, 7'h2B, 8'h5E, 8'h00, 8'h96);
    spurious_en = 0;
    tot += 3;
    if (tmo !== 1'b0)                    begin bad++; $display("[TB] FAIL stall_timeout: got %b expected 0", tmo); end
    if (cmd_log.size() != exp_log.size()) begin bad++; $display("[TB] FAIL stall_len: got %0d expected %0d", cmd_log.size(), exp_log.size()); end
    if (got_err !== 1'b0 || got_rd !== 8'h96)
      begin bad++; $display("[TB] FAIL stall_rsp: got err=%b rd=%h expected err=0 rd=96", got_err, got_rd); end
    for (int i = 0; i < exp_log.size() && i < cmd_log.size(); i++) begin
      tot++;
      if (cmd_log[i] !== exp_log[i]) begin bad++; $display("[TB] FAIL stall_cmd[%0d]: got %h expected %h", i, cmd_log[i], exp_log[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_nacks();
    ready_delay = 0; done_delay = 8; spurious_en = 0;
    cmd_log.delete();
    eng_attempt = 0; wr_idx = 0; ready_cnt = 0;
    @(negedge clk);
    req_rnw = 1'b0; req_dev_addr = 7'h50; req_reg_addr = 8'h10; req_wdata = 8'hA5; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!(cmd_log.size() == 3 && !cmd_valid) && n < 200) begin @(negedge clk); n++; end
    tot++;
    if (n >= 200) begin bad++; $display("[TB] FAIL midreset_reach_reg: got timeout expected REG wait"); end
    #1 reset = 1'b1;
    #1;
    tot += 4;
    if (req_ready !== 1'b1)  begin bad++; $display("[TB] FAIL midreset_req_ready: got %b expected 1", req_ready); end
    if (cmd_valid !== 1'b0 || cmd_op !== 2'b00 || cmd_wdata !== 8'h00)
      begin bad++; $display("[TB] FAIL midreset_cmd: got v=%b op=%b wd=%h expected v=0 op=00 wd=00", cmd_valid, cmd_op, cmd_wdata); end
    if (rsp_valid !== 1'b0)  begin bad++; $display("[TB] FAIL midreset_rsp_valid: got %b expected 0", rsp_valid); end
    if (rsp_rdata !== 8'h00 || rsp_error !== 1'b0)
      begin bad++; $display("[TB] FAIL midreset_rsp: got rd=%h err=%b expected rd=00 err=0", rsp_rdata, rsp_error); end
    @(negedge clk);
    #1 reset = 1'b0;
    done_delay = 0;
    drive_txn(1'b0, 7'h33, 8'h44, 8'h55);
    build_expected(1'b0, 7'h33, 8'h44, 8'h55, 8'h00);
    tot += 3;
    if (tmo !== 1'b0)                    begin bad++; $display("[TB] FAIL postreset_timeout: got %b expected 0", tmo); end
    if (cmd_log.size() != exp_log.size()) begin bad++; $display("[TB] FAIL postreset_len: got %0d expected %0d", cmd_log.size(), exp_log.size()); end
    if (got_err !== 1'b0)                begin bad++; $display("[TB] FAIL postreset_err: got %b expected 0", got_err); end
    for (int i = 0; i < exp_log.size() && i < cmd_log.size(); i++) begin
      tot++;
      if (cmd_log[i] !== exp_log[i]) begin bad++; $display("[TB] FAIL postreset_cmd[%0d]: got %h expected %h", i, cmd_log[i], exp_log[i]); end
    end
  endtask

  // Random requests issued back to back with random delays and NACK plans.
  task automatic test_random();
    logic       rnw;
    logic [6:0] dev;
    logic [7:0] ra;
    logic [7:0] wd;
    for (int t = 0; t < 30; t++) begin
      rnw = $urandom_range(0, 1);
      dev = 7'($urandom);
      ra  = 8'($urandom);
      wd  = 8'($urandom);
      rd_byte     = 8'($urandom);
      ready_delay = $urandom_range(0, 3);
      done_delay  = $urandom_range(0, 3);
      spurious_en = 0;
      for (int a = 0; a < 8; a++) nack_at[a] = ($urandom_range(0, 9) < 4) ? $urandom_range(0, 2) : 7;
      drive_txn(rnw, dev, ra, wd);
      build_expected(rnw, dev, ra, wd, rd_byte);
      tot += 4;
      if (tmo !== 1'b0)                    begin bad++; $display("[TB] FAIL rand%0d_timeout: got %b expected 0", t, tmo); end
      if (cmd_log.size() != exp_log.size()) begin bad++; $display("[TB] FAIL rand%0d_len: got %0d expected %0d", t, cmd_log.size(), exp_log.size()); end
      if (got_err !== exp_err || got_rd !== exp_rd)
        begin bad++; $display("[TB] FAIL rand%0d_rsp: got err=%b rd=%h expected err=%b rd=%h", t, got_err, got_rd, exp_err, exp_rd); end
      if (v_after !== 1'b0 || r_after !== 1'b1)
        begin bad++; $display("[TB] FAIL rand%0d_after: got v=%b rdy=%b expected v=0 rdy=1", t, v_after, r_after); end
      for (int i = 0; i < exp_log.size() && i < cmd_log.size(); i++) begin
        tot++;
        if (cmd_log[i] !== exp_log[i]) begin bad++; $display("[TB] FAIL rand%0d_cmd[%0d]: got %h expected %h", t, i, cmd_log[i], exp_log[i]); end
      end
    end
  endtask

  initial begin
    clear_nacks();
    test_reset();
    test_write();
    test_read();
    test_dev_nack();
    test_data_nack_retry();
    test_stall();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
